// File: rtl/data_mem_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl_if
// Brief    : Core data-side memory request/response bundle.
// Revision : 1.0
// ============================================================================
interface data_mem_ctrl_if;
    logic        data_mem_request;
    logic        data_mem_we_re;
    logic [3:0]  mask_singal;
    logic [31:0] alu_out_address;
    logic [31:0] store_data_out;
    logic [31:0] load_data_in;
    logic        data_mem_valid;
    logic        access_fault;

    modport master (
        output data_mem_request, data_mem_we_re, mask_singal,
               alu_out_address, store_data_out,
        input  load_data_in, data_mem_valid, access_fault
    );

    modport slave (
        input  data_mem_request, data_mem_we_re, mask_singal,
               alu_out_address, store_data_out,
        output load_data_in, data_mem_valid, access_fault
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Brief    : Word-organised data SRAM controller with WAIT wait states.
// Revision : 1.0
// ============================================================================
module data_mem_ctrl #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WAIT  = 1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    data_mem_ctrl_if.slave bus
);
    localparam int unsigned c_IDX_W    = $clog2(DEPTH);
    localparam bit          c_NO_WAIT  = (WAIT == 0);
    localparam logic [3:0]  c_CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_WAIT = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [3:0]         r_cnt;
    logic               r_we;
    logic [3:0]         r_mask;
    logic [c_IDX_W-1:0] r_idx;
    logic [31:0]        r_wdata;
    logic               r_oor;
    logic               r_valid;
    logic               r_fault;
    logic [31:0]        r_load_data;
    logic [31:0]        r_mem [DEPTH];

    logic               w_accept;
    logic               w_req_oor;
    logic               w_commit;
    logic               w_c_we;
    logic [3:0]         w_c_mask;
    logic [c_IDX_W-1:0] w_c_idx;
    logic [31:0]        w_c_wdata;
    logic               w_c_oor;
    logic               w_write;
    logic               w_unused_addr;

    assign w_unused_addr = ^bus.alu_out_address[1:0];

    assign w_accept  = (r_state == c_S_IDLE) && bus.data_mem_request;
    assign w_req_oor = ({2'b00, bus.alu_out_address[31:2]} >= 32'(DEPTH));

    // Without wait states the access commits on the capture edge itself,
    // so the operands come straight from the bus instead of the capture regs.
    assign w_commit  = c_NO_WAIT ? w_accept
                                 : ((r_state == c_S_WAIT) && (r_cnt == 4'd0));
    assign w_c_we    = c_NO_WAIT ? bus.data_mem_we_re : r_we;
    assign w_c_mask  = c_NO_WAIT ? bus.mask_singal    : r_mask;
    assign w_c_idx   = c_NO_WAIT ? bus.alu_out_address[c_IDX_W+1:2] : r_idx;
    assign w_c_wdata = c_NO_WAIT ? bus.store_data_out : r_wdata;
    assign w_c_oor   = c_NO_WAIT ? w_req_oor          : r_oor;

    // Reset gating keeps an aborted or reset-time access from touching the array.
    assign w_write = !rst && w_commit && w_c_we && !w_c_oor;

    always_ff @(posedge clk) begin
        if (w_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_c_mask[b]) begin
                    r_mem[w_c_idx][8*b +: 8] <= w_c_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_data <= 32'd0;
        end else if (w_commit) begin
            if (w_c_oor) begin
                r_load_data <= 32'd0;
            end else if (!w_c_we) begin
                r_load_data <= r_mem[w_c_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_mask  <= 4'd0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
            r_oor   <= 1'b0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_valid <= w_commit;
            r_fault <= w_commit && w_c_oor;
            case (r_state)
                c_S_IDLE: begin
                    if (bus.data_mem_request) begin
                        r_we    <= bus.data_mem_we_re;
                        r_mask  <= bus.mask_singal;
                        r_idx   <= bus.alu_out_address[c_IDX_W+1:2];
                        r_wdata <= bus.store_data_out;
                        r_oor   <= w_req_oor;
                        if (c_NO_WAIT) begin
                            r_state <= c_S_RESP;
                        end else begin
                            r_state <= c_S_WAIT;
                            r_cnt   <= c_CNT_INIT;
                        end
                    end
                end
                c_S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                // The core still holds the finished request here; never re-accept it.
                c_S_RESP: r_state <= c_S_IDLE;
                default:  r_state <= c_S_IDLE;
            endcase
        end
    end

    assign bus.load_data_in   = r_load_data;
    assign bus.data_mem_valid = r_valid;
    assign bus.access_fault   = r_fault;
endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_ctrl
// Brief    : Self-checking bench for data_mem_ctrl at WAIT = 0, 1 and 3.
// Revision : 1.0
// ============================================================================
module tb_data_mem_ctrl;
    localparam int c_N = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req   [c_N];
    logic        we    [c_N];
    logic [3:0]  mask  [c_N];
    logic [31:0] addr  [c_N];
    logic [31:0] wdata [c_N];
    logic [31:0] ld    [c_N];
    logic        vld   [c_N];
    logic        flt   [c_N];

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_mem [c_N][1024];
    logic [31:0] ref_ld  [c_N];

    typedef struct packed {
        logic [1:0]  k;
        logic        w;
        logic [3:0]  m;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_ld;
        logic        exp_f;
    } vec_t;

    vec_t vt [16];

    generate
        for (genvar k = 0; k < c_N; k++) begin : g_dut
            localparam int unsigned c_W = (k == 0) ? 0 : (k == 1) ? 1 : 3;
            data_mem_ctrl_if bus ();
            assign bus.data_mem_request = req[k];
            assign bus.data_mem_we_re   = we[k];
            assign bus.mask_singal      = mask[k];
            assign bus.alu_out_address  = addr[k];
            assign bus.store_data_out   = wdata[k];
            assign ld[k]  = bus.load_data_in;
            assign vld[k] = bus.data_mem_valid;
            assign flt[k] = bus.access_fault;
            data_mem_ctrl #(.DEPTH(1024), .WAIT(c_W)) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );
        end
    endgenerate

    function automatic int wait_of(int k);
        return (k == 0) ? 0 : (k == 1) ? 1 : 3;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference behaviour: word index beyond DEPTH faults and clears the
    // returned word; stores merge enabled bytes; loads return the whole word.
    task automatic model(int k, bit w, logic [3:0] m, logic [31:0] a,
                         logic [31:0] d, output bit f);
        int unsigned idx;
        idx = a >> 2;
        if (idx >= 1024) begin
            f = 1'b1;
            ref_ld[k] = 32'd0;
        end else begin
            f = 1'b0;
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (m[b]) ref_mem[k][idx][8*b +: 8] = d[8*b +: 8];
            end else begin
                ref_ld[k] = ref_mem[k][idx];
            end
        end
    endtask

    task automatic access(int k, bit w, logic [3:0] m, logic [31:0] a,
                          logic [31:0] d, bit hold,
                          output logic [31:0] got_ld, output logic got_f);
        int n;
        @(negedge clk);
        req[k] = 1'b1; we[k] = w; mask[k] = m; addr[k] = a; wdata[k] = d;
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vld[k] && n < 40);
        check($sformatf("latency[k=%0d]", k), n, wait_of(k) + 1);
        got_ld = ld[k];
        got_f  = flt[k];
        if (hold) wdata[k] = ~d;
        else      req[k] = 1'b0;
        @(negedge clk);
        check($sformatf("valid_one_cycle[k=%0d]", k), vld[k], 1'b0);
        req[k] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] g;
        logic        gf;
        bit          mf;
        int          n;
        logic [31:0] a, d;
        logic [3:0]  m;
        bit          w;

        for (int k = 0; k < c_N; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; mask[k] = 4'd0;
            addr[k] = 32'd0; wdata[k] = 32'd0; ref_ld[k] = 32'd0;
        end

        vt[0]  = '{2'd1, 1'b1, 4'hF, 32'h10,   32'hDEADBEEF, 32'h00000000, 1'b0};
        vt[1]  = '{2'd1, 1'b0, 4'hF, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
        vt[2]  = '{2'd1, 1'b1, 4'h2, 32'h10,   32'h0000AB00, 32'hDEADBEEF, 1'b0};
        vt[3]  = '{2'd1, 1'b0, 4'h0, 32'h13,   32'h0,        32'hDEADABEF, 1'b0};
        vt[4]  = '{2'd1, 1'b1, 4'hF, 32'h0,    32'h11111111, 32'hDEADABEF, 1'b0};
        vt[5]  = '{2'd1, 1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vt[6]  = '{2'd1, 1'b0, 4'hF, 32'h1000, 32'h0,        32'h00000000, 1'b1};
        vt[7]  = '{2'd1, 1'b0, 4'hF, 32'h0,    32'h0,        32'h11111111, 1'b0};
        vt[8]  = '{2'd1, 1'b1, 4'h0, 32'h0,    32'hAAAAAAAA, 32'h11111111, 1'b0};
        vt[9]  = '{2'd1, 1'b0, 4'hF, 32'h0,    32'h0,        32'h11111111, 1'b0};
        vt[10] = '{2'd0, 1'b1, 4'hF, 32'h40,   32'hCAFEF00D, 32'h00000000, 1'b0};
        vt[11] = '{2'd0, 1'b0, 4'hF, 32'h40,   32'h0,        32'hCAFEF00D, 1'b0};
        vt[12] = '{2'd0, 1'b1, 4'h9, 32'h40,   32'h12345678, 32'hCAFEF00D, 1'b0};
        vt[13] = '{2'd0, 1'b0, 4'hF, 32'h42,   32'h0,        32'h12FEF078, 1'b0};
        vt[14] = '{2'd2, 1'b1, 4'hF, 32'h20,   32'h0,        32'h00000000, 1'b0};
        vt[15] = '{2'd2, 1'b0, 4'hF, 32'h20,   32'h0,        32'h00000000, 1'b0};

        // Asynchronous reset asserted mid-cycle, sampled before any edge.
        #22 rst = 1'b1;
        #1;
        for (int k = 0; k < c_N; k++) begin
            check($sformatf("rst_valid[k=%0d]", k), vld[k], 1'b0);
            check($sformatf("rst_fault[k=%0d]", k), flt[k], 1'b0);
            check($sformatf("rst_load[k=%0d]", k),  ld[k],  32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            access(int'(vt[i].k), vt[i].w, vt[i].m, vt[i].a, vt[i].d, 1'b0, g, gf);
            check($sformatf("vec%0d_data", i),  g,  vt[i].exp_ld);
            check($sformatf("vec%0d_fault", i), gf, vt[i].exp_f);
            model(int'(vt[i].k), vt[i].w, vt[i].m, vt[i].a, vt[i].d, mf);
        end

        // Request held through RESP with changed data must not re-issue.
        access(0, 1'b1, 4'hF, 32'h44, 32'h5A5AA5A5, 1'b1, g, gf);
        model(0, 1'b1, 4'hF, 32'h44, 32'h5A5AA5A5, mf);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (vld[0]) n++;
        end
        check("held_extra_valid", n, 0);
        access(0, 1'b0, 4'hF, 32'h44, 32'h0, 1'b0, g, gf);
        model(0, 1'b0, 4'hF, 32'h44, 32'h0, mf);
        check("held_single_write", g, 32'h5A5AA5A5);

        // Reset one cycle after accept aborts a pending WAIT=3 store.
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b1; mask[2] = 4'hF;
        addr[2] = 32'h20; wdata[2] = 32'h12345678;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        req[2] = 1'b0;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (vld[2]) n++;
        end
        rst = 1'b0;
        for (int k = 0; k < c_N; k++) ref_ld[k] = 32'd0;
        repeat (6) begin
            @(negedge clk);
            if (vld[2]) n++;
        end
        check("abort_no_valid", n, 0);
        access(2, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, g, gf);
        model(2, 1'b0, 4'hF, 32'h20, 32'h0, mf);
        check("abort_no_write", g, 32'h0);

        // Randomised traffic against the reference model.
        for (int k = 0; k < c_N; k++) begin
            for (int i = 64; i < 80; i++) begin
                d = $urandom;
                access(k, 1'b1, 4'hF, i << 2, d, 1'b0, g, gf);
                model(k, 1'b1, 4'hF, i << 2, d, mf);
                check($sformatf("rinit[k=%0d]_fault", k), gf, mf);
            end
            for (int i = 0; i < 50; i++) begin
                w = $urandom_range(1);
                m = 4'($urandom_range(15));
                d = $urandom;
                if ($urandom_range(7) == 0)
                    a = 32'h1000 + $urandom_range(32'hFFFF_E000);
                else
                    a = ((64 + $urandom_range(15)) << 2) | $urandom_range(3);
                access(k, w, m, a, d, 1'b0, g, gf);
                model(k, w, m, a, d, mf);
                check($sformatf("rand[k=%0d,%0d]_data a=%08h", k, i, a), g, ref_ld[k]);
                check($sformatf("rand[k=%0d,%0d]_fault", k, i), gf, mf);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
